// File: rtl/axi4l_obi_bridge.sv
// Bridges the Ibex data port (req/gnt/rvalid) onto a single-outstanding AXI4-Lite master.
// An optional response timeout turns a hung slave into a bus error and drains the late response.
module axi4l_obi_bridge #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [31:0]    addr_reg, wdata_reg, rdata_reg;
    logic [3:0]     be_reg;
    logic           we_reg, err_reg, timed_out_reg;
    logic           aw_done_reg, w_done_reg, ar_done_reg;
    logic [CW-1:0]  cnt_reg;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_fin, w_fin, busy, expire;

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign ar_hs  = axi_arvalid && axi_arready;
    assign b_hs   = axi_bvalid && axi_bready;
    assign r_hs   = axi_rvalid && axi_rready;
    assign aw_fin = aw_done_reg || aw_hs;
    assign w_fin  = w_done_reg || w_hs;
    assign busy   = (state_reg == WADDR) || (state_reg == WRESP) ||
                    (state_reg == RADDR) || (state_reg == RDATA);
    // >= rather than == so a timeout that coincides with a partial completion still fires later.
    assign expire = (TIMEOUT > 0) && busy && (cnt_reg >= TLIM);

    logic unused_bits;
    assign unused_bits = ^{axi_bresp[0], axi_rresp[0], data_addr_i[1:0]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (data_gnt_o) state_next = data_we_i ? WADDR : RADDR;
            WADDR: if (aw_fin && w_fin) state_next = WRESP;
                   else if (expire)     state_next = RESP;
            WRESP: if (b_hs || expire) state_next = RESP;
            RADDR: if (ar_hs)       state_next = RDATA;
                   else if (expire) state_next = RESP;
            RDATA: if (r_hs || expire) state_next = RESP;
            RESP:  state_next = timed_out_reg ? DRAIN : IDLE;
            DRAIN: if (we_reg ? b_hs : r_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_gnt_o    = (state_reg == IDLE) && data_req_i && !areset;
        data_rvalid_o = (state_reg == RESP);
        // After a timeout the AXI side is still owed its handshakes, so valids persist in DRAIN.
        axi_awvalid   = ((state_reg == WADDR) || ((state_reg == DRAIN) && we_reg)) && !aw_done_reg;
        axi_wvalid    = ((state_reg == WADDR) || ((state_reg == DRAIN) && we_reg)) && !w_done_reg;
        axi_arvalid   = ((state_reg == RADDR) || ((state_reg == DRAIN) && !we_reg)) && !ar_done_reg;
        axi_bready    = (state_reg == WRESP) || (state_reg == DRAIN);
        axi_rready    = (state_reg == RDATA) || (state_reg == DRAIN);
    end

    assign axi_awaddr   = addr_reg;
    assign axi_araddr   = addr_reg;
    assign axi_wdata    = wdata_reg;
    assign axi_wstrb    = be_reg;
    assign axi_awprot   = 3'b000;
    assign axi_arprot   = 3'b000;
    assign data_rdata_o = rdata_reg;
    assign data_err_o   = err_reg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            we_reg        <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            timed_out_reg <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            ar_done_reg   <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            if (data_gnt_o) begin
                addr_reg      <= {data_addr_i[31:2], 2'b00};
                wdata_reg     <= data_wdata_i;
                be_reg        <= data_be_i;
                we_reg        <= data_we_i;
                timed_out_reg <= 1'b0;
                aw_done_reg   <= 1'b0;
                w_done_reg    <= 1'b0;
                ar_done_reg   <= 1'b0;
                cnt_reg       <= '0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
                if (ar_hs) ar_done_reg <= 1'b1;
                if (busy && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
            end
            if ((state_reg == WRESP) && b_hs) begin
                rdata_reg <= '0;
                err_reg   <= axi_bresp[1];
            end else if ((state_reg == RDATA) && r_hs) begin
                rdata_reg <= axi_rdata;
                err_reg   <= axi_rresp[1];
            end else if (expire && (state_next == RESP)) begin
                rdata_reg     <= '0;
                err_reg       <= 1'b1;
                timed_out_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4l_obi_bridge.sv
// Directed bench for axi4l_obi_bridge: a small AXI4-Lite slave model with stall, error
// and withheld-response knobs, plus hand-computed expectations per transaction.
module tb_axi4l_obi_bridge;

    localparam int TO = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [3:0]  axi_wstrb;

    always #5 aclk = ~aclk;

    axi4l_obi_bridge #(.TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    // ---------------- slave model ----------------
    int          aw_stall_cfg, aw_wait;
    logic        b_hold, b_pending, aw_got, w_got;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] mem [16];
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic        s_aw_hs, s_w_hs;
    logic [3:0]  s_idx, s_st;
    logic [31:0] s_wd;

    assign axi_awready = (aw_wait >= aw_stall_cfg);
    assign axi_wready  = 1'b1;
    assign axi_arready = 1'b1;
    assign s_aw_hs = axi_awvalid && axi_awready;
    assign s_w_hs  = axi_wvalid && axi_wready;
    assign s_idx   = s_aw_hs ? axi_awaddr[5:2] : cap_awaddr[5:2];
    assign s_wd    = s_w_hs ? axi_wdata : cap_wdata;
    assign s_st    = s_w_hs ? axi_wstrb : cap_wstrb;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            axi_bvalid <= 1'b0; axi_rvalid <= 1'b0; axi_bresp <= 2'b00; axi_rresp <= 2'b00;
            axi_rdata <= '0; aw_got <= 1'b0; w_got <= 1'b0; b_pending <= 1'b0; aw_wait <= 0;
            cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0; cap_araddr <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (s_aw_hs) begin
                aw_got <= 1'b1; cap_awaddr <= axi_awaddr; aw_wait <= 0;
            end else if (axi_awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (s_w_hs) begin
                w_got <= 1'b1; cap_wdata <= axi_wdata; cap_wstrb <= axi_wstrb;
            end
            if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                for (int i = 0; i < 4; i++)
                    if (s_st[i]) mem[s_idx][8*i +: 8] <= s_wd[8*i +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; axi_bresp <= bresp_cfg;
                if (b_hold) b_pending <= 1'b1;
                else        axi_bvalid <= 1'b1;
            end
            if (b_pending && !b_hold) begin
                axi_bvalid <= 1'b1; b_pending <= 1'b0;
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (axi_arvalid && axi_arready) begin
                cap_araddr <= axi_araddr; axi_rvalid <= 1'b1;
                axi_rdata <= mem[axi_araddr[5:2]]; axi_rresp <= rresp_cfg;
            end
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0, rv_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0;
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (data_rvalid_o)            rv_cnt <= rv_cnt + 1;
        if (axi_awvalid)              aw_hi  <= aw_hi + 1;
        if (axi_wvalid)               w_hi   <= w_hi + 1;
        if (axi_arvalid)              ar_hi  <= ar_hi + 1;
        if (axi_bvalid && axi_bready) b_hs   <= b_hs + 1;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_rvalid(output logic [31:0] rd, output logic er);
        int n = 0;
        while (!data_rvalid_o && n < 40) begin
            @(negedge aclk); #1; n++;
        end
        if (!data_rvalid_o) check("rvalid_seen", 32'd0, 32'd1);
        rd = data_rdata_o;
        er = data_err_o;
    endtask

    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output int gwait, output int lat,
                       output logic [31:0] rd, output logic er);
        int n = 0;
        int gc;
        @(negedge aclk);
        data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wd;
        #1;
        check("rv_idle", {31'd0, data_rvalid_o}, 32'd0);
        while (!data_gnt_o && n < 30) begin
            @(negedge aclk); #1; n++;
        end
        if (!data_gnt_o) check("gnt_seen", 32'd0, 32'd1);
        gwait = n;
        gc = cyc;
        @(negedge aclk);
        data_req_i = 1'b0;
        #1;
        wait_rvalid(rd, er);
        lat = cyc - gc;
        $display("txn we=%0b addr=0x%08h wd=0x%08h be=0x%h -> gwait=%0d lat=%0d rdata=0x%08h err=%0b",
                 we, addr, wd, be, gwait, lat, rd, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gw, lat, a0, w0, r0, rv0, bh0, n;
        logic [31:0] rd;
        logic er, gseen, bready_all;

        areset = 1'b1; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
        data_addr_i = '0; data_wdata_i = '0;
        aw_stall_cfg = 0; b_hold = 1'b0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        repeat (2) @(negedge aclk);
        #1;
        check("rst_gnt_rvalid_err", {29'd0, data_gnt_o, data_rvalid_o, data_err_o}, 32'd0);
        check("rst_rdata", data_rdata_o, 32'd0);
        check("rst_axi_ctrl", {27'd0, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 32'd0);
        areset = 1'b0;

        // basic write: AW/W together, rvalid at C3
        a0 = aw_hi; w0 = w_hi;
        txn(1'b1, 4'hF, 32'h0, 32'h5, gw, lat, rd, er);
        check("wr_lat", lat, 3);
        check("wr_err", {31'd0, er}, 0);
        check("wr_rdata0", rd, 0);
        check("led", mem[0], 32'h5);
        check("wr_wstrb", {28'd0, cap_wstrb}, 32'hF);
        check("wr_aw_cycles", aw_hi - a0, 1);
        check("wr_w_cycles", w_hi - w0, 1);

        // read back immediately: gnt at C4
        a0 = ar_hi;
        txn(1'b0, 4'hF, 32'h0, 32'h0, gw, lat, rd, er);
        check("rd_gwait", gw, 0);
        check("rd_lat", lat, 3);
        check("rd_data", rd, 32'h5);
        check("rd_err", {31'd0, er}, 0);
        check("rd_ar_cycles", ar_hi - a0, 1);

        // awready stalled 3 cycles, unaligned address
        aw_stall_cfg = 3; a0 = aw_hi; w0 = w_hi;
        txn(1'b1, 4'h3, 32'h13, 32'hCAFE1234, gw, lat, rd, er);
        aw_stall_cfg = 0;
        check("stall_lat", lat, 6);
        check("stall_aw_cycles", aw_hi - a0, 4);
        check("stall_w_cycles", w_hi - w0, 1);
        check("stall_awaddr", cap_awaddr, 32'h10);
        check("stall_mem", mem[4], 32'h0000_1234);

        // partial byte enables, then read with be=0 and unaligned address
        txn(1'b1, 4'h5, 32'h4, 32'hAABBCCDD, gw, lat, rd, er);
        check("be_mem", mem[1], 32'h00BB00DD);
        txn(1'b0, 4'h0, 32'h6, 32'h0, gw, lat, rd, er);
        check("be_rd", rd, 32'h00BB00DD);
        check("be_araddr", cap_araddr, 32'h4);

        // slave errors
        rresp_cfg = 2'b10;
        txn(1'b0, 4'hF, 32'h10, 32'h0, gw, lat, rd, er);
        rresp_cfg = 2'b00;
        check("slverr_r_err", {31'd0, er}, 1);
        check("slverr_r_data", rd, 32'h0000_1234);
        bresp_cfg = 2'b10;
        txn(1'b1, 4'hF, 32'hC, 32'h1, gw, lat, rd, er);
        bresp_cfg = 2'b00;
        check("slverr_b_err", {31'd0, er}, 1);
        check("slverr_b_rdata", rd, 0);

        // timeout: B withheld
        b_hold = 1'b1;
        txn(1'b1, 4'hF, 32'h8, 32'h77, gw, lat, rd, er);
        check("to_lat", lat, 9);
        check("to_err", {31'd0, er}, 1);
        check("to_rdata", rd, 0);
        gseen = 1'b0; bready_all = 1'b1; rv0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0; data_be_i = 4'hF;
            #1;
            if (i == 0) rv0 = rv_cnt;
            gseen = gseen | data_gnt_o;
            bready_all = bready_all & axi_bready;
        end
        check("drain_no_gnt", {31'd0, gseen}, 0);
        check("drain_bready", {31'd0, bready_all}, 1);
        @(negedge aclk);
        b_hold = 1'b0; bh0 = b_hs;
        #1;
        n = 0;
        while (!data_gnt_o && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        check("drain_gnt_wait", n, 2);
        check("drain_b_absorbed", b_hs - bh0, 1);
        check("drain_no_rvalid", rv_cnt - rv0, 0);
        @(negedge aclk);
        data_req_i = 1'b0;
        #1;
        wait_rvalid(rd, er);
        $display("txn post-drain read addr=0x00000000 -> rdata=0x%08h err=%0b", rd, er);
        check("drain_next_rd", rd, 32'h5);

        // reset while in WRESP
        b_hold = 1'b1;
        @(negedge aclk);
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h20; data_wdata_i = 32'h99; data_be_i = 4'hF;
        @(negedge aclk);
        data_req_i = 1'b0;
        @(negedge aclk);
        #1;
        check("pre_rst_bready", {31'd0, axi_bready}, 1);
        rv0 = rv_cnt;
        areset = 1'b1;
        #1;
        check("rst_mid_axi", {28'd0, axi_awvalid, axi_wvalid, axi_bready, data_rvalid_o}, 0);
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0;
        @(negedge aclk);
        areset = 1'b0; b_hold = 1'b0;
        #1;
        check("rst_gnt_next", {31'd0, data_gnt_o}, 1);
        @(negedge aclk);
        data_req_i = 1'b0;
        #1;
        wait_rvalid(rd, er);
        $display("txn post-reset read addr=0x00000000 -> rdata=0x%08h err=%0b", rd, er);
        check("rst_no_stale_rvalid", rv_cnt - rv0, 0);
        check("rst_rd_err", {31'd0, er}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
